// File: rtl/pipe_ctrl.sv
// Y86-64 five-stage pipeline control: hazard stall/bubble generation plus a FLUSH/RUN/STOPPED run-state machine.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined; otherwise they read as zero.
module pipe_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       W_icode,
    input  logic [3:0]       E_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic             e_Cnd,
    input  logic [1:0]       m_stat,
    input  logic [1:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             set_cc,
    output logic [1:0]       stat,
    output logic             running,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt,
    output logic [CNT_W-1:0] ret_cnt
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [1:0] S_AOK    = 2'd0;

    typedef enum logic [1:0] {
        ST_FLUSH   = 2'd0,
        ST_RUN     = 2'd1,
        ST_STOPPED = 2'd2
    } state_t;

    state_t     state, state_d;
    logic [1:0] stat_d;
    logic       lu, mp, rt, exc_m, exc_w;

    // Hazard detection terms
    assign lu    = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != R_NONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign mp    = (E_icode == I_JXX) && !e_Cnd;
    assign rt    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign exc_m = (m_stat != S_AOK);
    assign exc_w = (W_stat != S_AOK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FLUSH;
            stat  <= S_AOK;
        end else begin
            state <= state_d;
            stat  <= stat_d;
        end
    end

    // Next state, latched status and per-stage controls
    always_comb begin
        state_d  = state;
        stat_d   = stat;
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        W_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        set_cc   = 1'b0;
        case (state)
            ST_FLUSH: begin
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                F_stall  = lu | rt;
                D_stall  = lu;
                // load-use wins over ret so D is never both stalled and bubbled
                D_bubble = mp | (rt & !lu);
                E_bubble = mp | lu;
                M_bubble = exc_m | exc_w;
                W_stall  = exc_w;
                set_cc   = (E_icode == I_OPQ) && !exc_m && !exc_w;
                if (exc_w) begin
                    stat_d  = W_stat;
                    state_d = ST_STOPPED;
                end
            end
            ST_STOPPED: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                W_stall  = 1'b1;
                M_bubble = 1'b1;
            end
            default: state_d = ST_FLUSH;
        endcase
    end

    assign running = (state == ST_RUN);

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q, instr_q, lu_q, mp_q, ret_q;

    // Event counters advance only while the pipe is running
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q <= '0;
            instr_q <= '0;
            lu_q    <= '0;
            mp_q    <= '0;
            ret_q   <= '0;
        end else if (state == ST_RUN) begin
            cycle_q <= cycle_q + CNT_W'(1);
            if ((W_stat == S_AOK) && (W_icode != I_NOP) && !W_stall)
                instr_q <= instr_q + CNT_W'(1);
            if (lu)
                lu_q <= lu_q + CNT_W'(1);
            if (mp)
                mp_q <= mp_q + CNT_W'(1);
            if (rt && !lu)
                ret_q <= ret_q + CNT_W'(1);
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
    assign lu_cnt    = lu_q;
    assign mp_cnt    = mp_q;
    assign ret_cnt   = ret_q;
`else
    logic unused_w_icode;

    assign unused_w_icode = ^W_icode;
    assign cycle_cnt      = '0;
    assign instr_cnt      = '0;
    assign lu_cnt         = '0;
    assign mp_cnt         = '0;
    assign ret_cnt        = '0;
`endif

endmodule
